// File: rtl/display_pkg.sv
// Shared 640x480@60 raster timing constants for the timing generator and renderers.
// Latency: n/a (constants and an elaboration-time helper only).
// Backpressure: n/a.
package display_pkg;

  // Sum of the four segments of one scan axis (active + porches + sync).
  function automatic int line_total(input int res, input int fp, input int sync, input int bp);
    return res + fp + sync + bp;
  endfunction

  localparam int CORDW  = 10;

  localparam int H_RES  = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;

  localparam int V_RES  = 480;
  localparam int V_FP   = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 33;

  localparam int H_TOT  = line_total(H_RES, H_FP, H_SYNC, H_BP);  // 800
  localparam int V_TOT  = line_total(V_RES, V_FP, V_SYNC, V_BP);  // 525

  localparam int H_SYNC_BEG = H_RES + H_FP;                 // 656
  localparam int H_SYNC_END = H_RES + H_FP + H_SYNC - 1;    // 751
  localparam int V_SYNC_BEG = V_RES + V_FP;                 // 490
  localparam int V_SYNC_END = V_RES + V_FP + V_SYNC - 1;    // 491

endpackage

// File: rtl/sync_delay.sv
// WIDTH x DEPTH shift register that advances only on ce; DEPTH=0 is a plain wire.
// Latency: DEPTH ce-cycles. Reset loads every stage with RST_VAL.
// Backpressure: none; ce low freezes all stages.
//   clk, rst  : clock, synchronous active-high reset
//   ce        : shift enable
//   i_dat     : word entering the line
//   o_dat     : word from DEPTH ce-cycles earlier
module sync_delay #(
  parameter int               WIDTH   = 3,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] i_dat,
  output logic [WIDTH-1:0] o_dat
);

  generate
    if (DEPTH == 0) begin : g_pass
      // No register at all: output follows input combinationally.
      logic w_unused;
      assign w_unused = ^{clk, rst, ce};
      assign o_dat    = i_dat;
    end else begin : g_shift
      logic [WIDTH-1:0] r_stage [DEPTH];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) r_stage[i] <= RST_VAL;
        end else if (ce) begin
          r_stage[0] <= i_dat;
          for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
      end

      assign o_dat = r_stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/display_timing.sv
// Raster timing generator: coordinates, syncs, data-enable, line/frame strobes, frame counter.
// Latency: outputs lag the internal h/v counters by 1 ce-cycle; *_d outputs add PIPE_DLY more.
// Backpressure: ce low holds all state; line/frame read 0 while ce is low.
//   clk, rst, ce        : pixel clock, synchronous active-high reset, pixel enable
//   sx, sy, de          : coordinates and active-video flag
//   hsync, vsync        : syncs (active level SYNC_POL), aligned with sx/sy
//   line, frame         : one-ce-cycle strobes at sx==0 / (sx==0, sy==V_RES)
//   frame_cnt           : number of frame strobes, wraps at 2^16
//   hsync_d/vsync_d/de_d: hsync/vsync/de delayed by PIPE_DLY ce-cycles
module display_timing #(
  parameter int CORDW    = display_pkg::CORDW,
  parameter int H_RES    = display_pkg::H_RES,
  parameter int H_FP     = display_pkg::H_FP,
  parameter int H_SYNC   = display_pkg::H_SYNC,
  parameter int H_BP     = display_pkg::H_BP,
  parameter int V_RES    = display_pkg::V_RES,
  parameter int V_FP     = display_pkg::V_FP,
  parameter int V_SYNC   = display_pkg::V_SYNC,
  parameter int V_BP     = display_pkg::V_BP,
  parameter bit SYNC_POL = 1'b0,
  parameter int PIPE_DLY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  output logic [CORDW-1:0] sx,
  output logic [CORDW-1:0] sy,
  output logic             de,
  output logic             hsync,
  output logic             vsync,
  output logic             line,
  output logic             frame,
  output logic [15:0]      frame_cnt,
  output logic             hsync_d,
  output logic             vsync_d,
  output logic             de_d
);

  import display_pkg::*;

  localparam int H_TOT = line_total(H_RES, H_FP, H_SYNC, H_BP);
  localparam int V_TOT = line_total(V_RES, V_FP, V_SYNC, V_BP);

  generate
    if (H_TOT > (1 << CORDW) || V_TOT > (1 << CORDW)) begin : g_bad_cordw
      $error("display_timing: H_TOT/V_TOT do not fit in CORDW bits");
    end
    if (PIPE_DLY < 0 || PIPE_DLY > 15) begin : g_bad_dly
      $error("display_timing: PIPE_DLY must be 0..15");
    end
  endgenerate

  // All decode thresholds at counter width so comparisons are width-matched.
  localparam logic [CORDW-1:0] H_LAST = CORDW'(H_TOT - 1);
  localparam logic [CORDW-1:0] V_LAST = CORDW'(V_TOT - 1);
  localparam logic [CORDW-1:0] H_ACT  = CORDW'(H_RES);
  localparam logic [CORDW-1:0] V_ACT  = CORDW'(V_RES);
  localparam logic [CORDW-1:0] HS_BEG = CORDW'(H_RES + H_FP);
  localparam logic [CORDW-1:0] HS_END = CORDW'(H_RES + H_FP + H_SYNC - 1);
  localparam logic [CORDW-1:0] VS_BEG = CORDW'(V_RES + V_FP);
  localparam logic [CORDW-1:0] VS_END = CORDW'(V_RES + V_FP + V_SYNC - 1);

  logic [CORDW-1:0] r_h, r_v;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_h <= '0;
      r_v <= '0;
    end else if (ce) begin
      if (r_h == H_LAST) begin
        r_h <= '0;
        r_v <= (r_v == V_LAST) ? '0 : r_v + 1'b1;
      end else begin
        r_h <= r_h + 1'b1;
      end
    end
  end

  // Decode of the current (h,v); registered below so every output shares one timing.
  logic w_de, w_hs_act, w_vs_act, w_line, w_frame;
  assign w_de     = (r_h < H_ACT) && (r_v < V_ACT);
  assign w_hs_act = (r_h >= HS_BEG) && (r_h <= HS_END);
  assign w_vs_act = (r_v >= VS_BEG) && (r_v <= VS_END);
  assign w_line   = (r_h == '0);
  assign w_frame  = w_line && (r_v == V_ACT);

  logic [CORDW-1:0] r_sx, r_sy;
  logic             r_de, r_hsync, r_vsync, r_line, r_frame;
  logic [15:0]      r_frame_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sx        <= '0;
      r_sy        <= '0;
      r_de        <= 1'b0;
      r_hsync     <= ~SYNC_POL;
      r_vsync     <= ~SYNC_POL;
      r_line      <= 1'b0;
      r_frame     <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      // Strobes last exactly one clock: cleared on every non-ce cycle.
      r_line  <= 1'b0;
      r_frame <= 1'b0;
      if (ce) begin
        r_sx    <= r_h;
        r_sy    <= r_v;
        r_de    <= w_de;
        r_hsync <= w_hs_act ? SYNC_POL : ~SYNC_POL;
        r_vsync <= w_vs_act ? SYNC_POL : ~SYNC_POL;
        r_line  <= w_line;
        r_frame <= w_frame;
        // Counter updates together with the strobe so its new value is seen alongside frame=1.
        if (w_frame) r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  assign sx        = r_sx;
  assign sy        = r_sy;
  assign de        = r_de;
  assign hsync     = r_hsync;
  assign vsync     = r_vsync;
  assign line      = r_line;
  assign frame     = r_frame;
  assign frame_cnt = r_frame_cnt;

  // Re-time syncs and de to the renderer's pixel pipeline; idle word is "syncs inactive, de low".
  logic [2:0] w_dly_in, w_dly_out;
  assign w_dly_in = {r_hsync, r_vsync, r_de};

  sync_delay #(
    .WIDTH   (3),
    .DEPTH   (PIPE_DLY),
    .RST_VAL ({~SYNC_POL, ~SYNC_POL, 1'b0})
  ) u_sync_delay (
    .clk   (clk),
    .rst   (rst),
    .ce    (ce),
    .i_dat (w_dly_in),
    .o_dat (w_dly_out)
  );

  assign {hsync_d, vsync_d, de_d} = w_dly_out;

endmodule

// File: tb/tb_display_timing.sv
// Self-checking bench: three display_timing instances (full 640x480, two reduced rasters)
// driven by shared rst/ce; every clock is compared against an arithmetic raster model.
module tb_display_timing;

  typedef struct packed {
    int hres; int hfp; int hsy; int hbp;
    int vres; int vfp; int vsy; int vbp;
    bit pol;
  } geom_t;

  typedef struct packed {
    int sx; int sy;
    bit de; bit hs; bit vs;
  } pix_t;

  logic clk = 1'b0;
  logic rst, ce;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // --- instance A: default 640x480, PIPE_DLY=2, active-low syncs
  logic [9:0]  a_sx, a_sy;
  logic        a_de, a_hs, a_vs, a_line, a_frame, a_hsd, a_vsd, a_ded;
  logic [15:0] a_fc;
  display_timing dut_a (
    .clk(clk), .rst(rst), .ce(ce), .sx(a_sx), .sy(a_sy), .de(a_de), .hsync(a_hs), .vsync(a_vs),
    .line(a_line), .frame(a_frame), .frame_cnt(a_fc), .hsync_d(a_hsd), .vsync_d(a_vsd), .de_d(a_ded));

  // --- instance B: 24x15 raster, PIPE_DLY=2, active-low syncs
  logic [5:0]  b_sx, b_sy;
  logic        b_de, b_hs, b_vs, b_line, b_frame, b_hsd, b_vsd, b_ded;
  logic [15:0] b_fc;
  display_timing #(.CORDW(6), .H_RES(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
                   .V_RES(8), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b0), .PIPE_DLY(2)) dut_b (
    .clk(clk), .rst(rst), .ce(ce), .sx(b_sx), .sy(b_sy), .de(b_de), .hsync(b_hs), .vsync(b_vs),
    .line(b_line), .frame(b_frame), .frame_cnt(b_fc), .hsync_d(b_hsd), .vsync_d(b_vsd), .de_d(b_ded));

  // --- instance C: 14x8 raster, PIPE_DLY=0, active-high syncs
  logic [4:0]  c_sx, c_sy;
  logic        c_de, c_hs, c_vs, c_line, c_frame, c_hsd, c_vsd, c_ded;
  logic [15:0] c_fc;
  display_timing #(.CORDW(5), .H_RES(10), .H_FP(1), .H_SYNC(2), .H_BP(1),
                   .V_RES(4), .V_FP(1), .V_SYNC(1), .V_BP(2), .SYNC_POL(1'b1), .PIPE_DLY(0)) dut_c (
    .clk(clk), .rst(rst), .ce(ce), .sx(c_sx), .sy(c_sy), .de(c_de), .hsync(c_hs), .vsync(c_vs),
    .line(c_line), .frame(c_frame), .frame_cnt(c_fc), .hsync_d(c_hsd), .vsync_d(c_vsd), .de_d(c_ded));

  geom_t g_a, g_b, g_c;

  // Model state: ce-cycles since reset, whether the last edge was a ce edge, frame counts.
  longint n_ce;
  bit     last_ce;
  int     fc_a, fc_b, fc_c;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d, expected %0d", tag, $time, obs, exp);
    end
  endtask

  // Output word after n ce-cycles: position n-1 of the raster, or the reset word if n<=0.
  function automatic pix_t predict(input geom_t g, input longint n);
    pix_t   r;
    int     htot, vtot;
    longint p;
    htot = g.hres + g.hfp + g.hsy + g.hbp;
    vtot = g.vres + g.vfp + g.vsy + g.vbp;
    if (n <= 0) begin
      r.sx = 0; r.sy = 0; r.de = 1'b0; r.hs = ~g.pol; r.vs = ~g.pol;
    end else begin
      p    = (n - 1) % longint'(htot * vtot);
      r.sx = int'(p % htot);
      r.sy = int'(p / htot);
      r.de = (r.sx < g.hres) && (r.sy < g.vres);
      r.hs = (r.sx >= g.hres + g.hfp && r.sx < g.hres + g.hfp + g.hsy) ? g.pol : ~g.pol;
      r.vs = (r.sy >= g.vres + g.vfp && r.sy < g.vres + g.vfp + g.vsy) ? g.pol : ~g.pol;
    end
    return r;
  endfunction

  function automatic bit is_frame_pos(input geom_t g, input longint n);
    pix_t e;
    e = predict(g, n);
    return (n > 0) && (e.sx == 0) && (e.sy == g.vres);
  endfunction

  task automatic check_inst(input string nm, input geom_t g, input int dly, input int fc,
                            input logic [31:0] sx, input logic [31:0] sy, input logic de,
                            input logic hs, input logic vs, input logic ln, input logic fr,
                            input logic [31:0] fcnt, input logic hsd, input logic vsd, input logic ded);
    pix_t e, ed;
    e  = predict(g, n_ce);
    ed = predict(g, n_ce - dly);
    check({nm, ".sx"},        sx,   32'(e.sx));
    check({nm, ".sy"},        sy,   32'(e.sy));
    check({nm, ".de"},        32'(de), 32'(e.de));
    check({nm, ".hsync"},     32'(hs), 32'(e.hs));
    check({nm, ".vsync"},     32'(vs), 32'(e.vs));
    check({nm, ".line"},      32'(ln), 32'(last_ce && n_ce > 0 && e.sx == 0));
    check({nm, ".frame"},     32'(fr), 32'(last_ce && is_frame_pos(g, n_ce)));
    check({nm, ".frame_cnt"}, fcnt, 32'(fc));
    check({nm, ".hsync_d"},   32'(hsd), 32'(ed.hs));
    check({nm, ".vsync_d"},   32'(vsd), 32'(ed.vs));
    check({nm, ".de_d"},      32'(ded), 32'(ed.de));
  endtask

  // One clock: update the model with the inputs seen at the edge, then compare at the falling edge.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      n_ce = 0; last_ce = 1'b0; fc_a = 0; fc_b = 0; fc_c = 0;
    end else if (ce) begin
      n_ce++;
      last_ce = 1'b1;
      if (is_frame_pos(g_a, n_ce)) fc_a = (fc_a + 1) % 65536;
      if (is_frame_pos(g_b, n_ce)) fc_b = (fc_b + 1) % 65536;
      if (is_frame_pos(g_c, n_ce)) fc_c = (fc_c + 1) % 65536;
    end else begin
      last_ce = 1'b0;
    end
    @(negedge clk);
    check_inst("A", g_a, 2, fc_a, 32'(a_sx), 32'(a_sy), a_de, a_hs, a_vs, a_line, a_frame,
               32'(a_fc), a_hsd, a_vsd, a_ded);
    check_inst("B", g_b, 2, fc_b, 32'(b_sx), 32'(b_sy), b_de, b_hs, b_vs, b_line, b_frame,
               32'(b_fc), b_hsd, b_vsd, b_ded);
    check_inst("C", g_c, 0, fc_c, 32'(c_sx), 32'(c_sy), c_de, c_hs, c_vs, c_line, c_frame,
               32'(c_fc), c_hsd, c_vsd, c_ded);
  endtask

  initial begin
    g_a = '{hres:640, hfp:16, hsy:96, hbp:48, vres:480, vfp:10, vsy:2, vbp:33, pol:1'b0};
    g_b = '{hres:16,  hfp:2,  hsy:3,  hbp:3,  vres:8,   vfp:2,  vsy:2, vbp:3,  pol:1'b0};
    g_c = '{hres:10,  hfp:1,  hsy:2,  hbp:1,  vres:4,   vfp:1,  vsy:1, vbp:2,  pol:1'b1};
    n_ce = 0; last_ce = 1'b0; fc_a = 0; fc_b = 0; fc_c = 0;

    // Reset held for a few clocks with ce high: reset state must dominate.
    rst = 1'b1; ce = 1'b1;
    repeat (3) step();
    rst = 1'b0;

    // Continuous ce: spans several 640-wide lines and many reduced frames.
    repeat (2500) step();

    // Random ce pattern.
    for (int i = 0; i < 3000; i++) begin
      ce = 1'(($urandom_range(0, 1)));
      step();
    end

    // Strict 1/0 alternation.
    for (int i = 0; i < 400; i++) begin
      ce = 1'(i % 2 == 0);
      step();
    end

    // Mid-raster reset with ce low, then resume.
    ce = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0; ce = 1'b1;
    repeat (($urandom_range(50, 900))) step();

    // One-cycle reset with ce high at a random raster position, then random ce.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      ce = 1'(($urandom_range(0, 3) != 0));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/display_timing.md
Name: display_timing

Overview:
- Generates 640x480@60 display raster timing: pixel coordinates, sync pulses, data-enable and frame/line strobes.
- It is the producer side of the sx/sy coordinate interface consumed by the pattern/render blocks; its hsync/vsync/de feed the HDMI/TMDS encoder.
- A parameterised delay line re-times hsync/vsync/de to match the pixel-pipeline latency of the downstream renderer.

Parameters:
- CORDW, 10, coordinate width in bits
- H_RES, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_RES, 480, active lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low)
- PIPE_DLY, 2, cycles of delay on the hsync_d/vsync_d/de_d outputs (0..15)

Ports:
- clk  in  1  pixel clock; all logic is on the rising edge
- rst  in  1  synchronous reset, active-high
- ce  in  1  pixel enable; when low, all state holds
- sx  out  CORDW  horizontal coordinate, 0..H_TOT-1
- sy  out  CORDW  vertical coordinate, 0..V_TOT-1
- de  out  1  high when sx<H_RES and sy<V_RES
- hsync  out  1  horizontal sync, aligned with sx/sy
- vsync  out  1  vertical sync, aligned with sx/sy
- line  out  1  one-ce-cycle strobe when sx==0
- frame  out  1  one-ce-cycle strobe when sx==0 and sy==V_RES (start of vertical blanking)
- frame_cnt  out  16  count of frame strobes; wraps modulo 2^16
- hsync_d  out  1  hsync delayed by PIPE_DLY ce-cycles
- vsync_d  out  1  vsync delayed by PIPE_DLY ce-cycles
- de_d  out  1  de delayed by PIPE_DLY ce-cycles

Behaviour:
- Totals: H_TOT=H_RES+H_FP+H_SYNC+H_BP (800); V_TOT=V_RES+V_FP+V_SYNC+V_BP (525). Both must fit in CORDW bits; elaboration fails otherwise.
- Internal counters h and v, both reset to 0. On a ce cycle:
  - h wraps from H_TOT-1 to 0; otherwise h increments.
  - v increments only when h wraps. v wraps from V_TOT-1 to 0 when h wraps.
- Output stage registers every decoded output from the same (h,v), so all outputs are mutually aligned and lag the counters by exactly 1 ce-cycle:
  - sx=h, sy=v, de=(h<H_RES && v<V_RES).
  - hsync=SYNC_POL when h is in [H_RES+H_FP, H_RES+H_FP+H_SYNC-1] (656..751); otherwise ~SYNC_POL.
  - vsync=SYNC_POL when v is in [V_RES+V_FP, V_RES+V_FP+V_SYNC-1] (490..491); otherwise ~SYNC_POL.
  - line=(h==0). frame=(h==0 && v==V_RES).
- Strobes (line, frame) are high for exactly one ce-cycle. When ce is low, line and frame are forced to 0; all other outputs hold their values.
- frame_cnt increments in the same cycle that frame is asserted, i.e. its new value is visible on the first cycle frame=1. 0xFFFF wraps to 0.
- Reset values: sx=0, sy=0, de=0, hsync=vsync=~SYNC_POL, line=0, frame=0, frame_cnt=0. All delay-line stages hold (de=0, syncs inactive) after reset.
- First ce-cycle after rst falls: outputs show sx=0, sy=0, de=1, line=1.
- Reset asserted mid-frame: takes effect on the next edge regardless of ce, and restarts the raster at (0,0). No partial strobes are emitted.
- Delay line:
  - Shifts only on ce.
  - PIPE_DLY=0 gives hsync_d=hsync, vsync_d=vsync, de_d=de with no extra register.
  - Default PIPE_DLY=2 matches the renderer's two-register RGB path.
- Sync outputs are glitch-free because they are driven straight from flops.

Decomposition:
- Shared package display_pkg:
  - CORDW
  - 640x480 timing constants (H_RES, H_FP, H_SYNC, H_BP, V_RES, V_FP, V_SYNC, V_BP)
  - derived H_TOT, V_TOT
  - sync-region start/end constants
- Pattern/render blocks import the same package for H_RES/V_RES.
- One sub-module, sync_delay: a WIDTH x DEPTH ce-gated shift register with synchronous reset to a parameterised reset word. It is instantiated once for {hsync, vsync, de}.

Test Plan:
- Reset, then 5 ce-cycles -> sx goes 0,1,2,3,4; sy=0; de=1. Cycle 1 line=1; frame=0; hsync=vsync=1.
- Run to the end of line 0 -> sx 799 is followed by sx=0, sy=1, line=1. hsync=0 exactly for sx 656..751 (96 cycles). de=0 for sx 640..799.
- Run a full frame -> frame=1 only at (sx=0, sy=480) and frame_cnt=1 in that cycle. vsync=0 for sy 490..491 (1600 cycles). Next frame=1 comes exactly 420000 ce-cycles later.
- Toggle ce 1/0 alternately -> the coordinate sequence matches the ce=1 run with each value held 2 clocks. line/frame are high for only one clock per event.
- Assert rst for 1 cycle at sx=300, sy=200 -> next outputs are the reset values, then sx=0, sy=0 resumes. frame_cnt=0.
- PIPE_DLY=2 -> de_d/hsync_d/vsync_d equal de/hsync/vsync from 2 ce-cycles earlier throughout a full frame. PIPE_DLY=0 -> they are identical.
